csa_booth_mult_ctrl: RTL and testbench

- Multi-cycle signed 32x32 multiplier sequencer using radix-2 Booth.
- Each iteration drives one shared internal 32-bit carry-select adder (ports dataA, dataB, Cin, Ovf, Cout, Sum) to add, subtract or skip the multiplicand, then arithmetic-shifts the partial product.
- Returns the low 32 bits of the product, plus an overflow exception, to the ALU issue logic via a start/ready handshake.

---
 rtl/csa_booth_mult_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_csa_booth_mult_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/csa_booth_mult_ctrl.sv
// csa_booth_mult_ctrl -- multi-cycle signed 32x32 radix-2 Booth multiplier
// sequencer built around one shared 32-bit carry-select adder.
//
// Ports:
//   clock           system clock, rising edge
//   reset           synchronous, active-high; clears all state
//   ctrl_mult       start strobe (restarts the operation if seen while busy)
//   data_operandA   multiplicand, two's complement, sampled on accepted start
//   data_operandB   multiplier, two's complement, sampled on accepted start
//   data_result     product[31:0]
//   data_exception  product does not fit in 32 signed bits
//   data_resultRDY  one-cycle result-valid pulse
//   busy            high while iterating (state RUN)
//
// Parameter HOLD_RESULT: 1 holds result/exception after the ready pulse,
// 0 clears them when the ready pulse drops.
// Optional macro MULT_ZERO_BYPASS_EN: a start with a zero operand skips the
// Booth iterations and reports a zero result one cycle later.

// One carry-select lane: both carry-in hypotheses computed in parallel.
module csa_lane #(
  parameter int VEC_W = 4
) (
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic [VEC_W-1:0] sum0,
  output logic [VEC_W-1:0] sum1,
  output logic             cout0,
  output logic             cout1
);
  assign {cout0, sum0} = {1'b0, a} + {1'b0, b};
  assign {cout1, sum1} = {1'b0, a} + {1'b0, b} + {{VEC_W{1'b0}}, 1'b1};
endmodule

// Carry-select adder: lanes precompute, the carry chain only steers muxes.
module csa_adder32 #(
  parameter int NUM_LANES = 8,
  parameter int VEC_W     = 4
) (
  input  logic [NUM_LANES*VEC_W-1:0] dataA,
  input  logic [NUM_LANES*VEC_W-1:0] dataB,
  input  logic                       Cin,
  output logic [NUM_LANES*VEC_W-1:0] Sum,
  output logic                       Cout,
  output logic                       Ovf
);
  localparam int W = NUM_LANES * VEC_W;

  logic [NUM_LANES-1:0][VEC_W-1:0] a_l, b_l, s0, s1, s_l;
  logic [NUM_LANES-1:0]            c0, c1;
  logic [NUM_LANES:0]              c;

  assign a_l  = dataA;
  assign b_l  = dataB;
  assign c[0] = Cin;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    csa_lane #(.VEC_W(VEC_W)) u_lane (
      .a(a_l[g]), .b(b_l[g]), .sum0(s0[g]), .sum1(s1[g]),
      .cout0(c0[g]), .cout1(c1[g])
    );
    assign s_l[g]  = c[g] ? s1[g] : s0[g];
    assign c[g+1]  = c[g] ? c1[g] : c0[g];
  end

  assign Sum  = s_l;
  assign Cout = c[NUM_LANES];
  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign Ovf  = (dataA[W-1] == dataB[W-1]) && (Sum[W-1] != dataA[W-1]);
endmodule

module csa_booth_mult_ctrl #(
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] m, hi, lo;
  logic        q1;
  logic [5:0]  cnt;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_ovf, cout_unused;
  logic [31:0] step_hi, sh_hi, sh_lo;
  logic        step_sign, sh_q1;
  logic        start_zero;

`ifdef MULT_ZERO_BYPASS_EN
  logic zpend;  // zero-operand start accepted last edge; report next edge
  assign start_zero = (data_operandA == 32'd0) || (data_operandB == 32'd0);
`else
  assign start_zero = 1'b0;
`endif

  assign busy = (state == RUN);

  // Adder operands: {LO[0],Q1}=10 subtracts M via ~M + 1.
  always_comb begin
    add_a   = hi;
    add_b   = m;
    add_cin = 1'b0;
    if (lo[0] && !q1) begin
      add_b   = ~m;
      add_cin = 1'b1;
    end
  end

  csa_adder32 #(.NUM_LANES(8), .VEC_W(4)) u_add (
    .dataA(add_a), .dataB(add_b), .Cin(add_cin),
    .Sum(add_sum), .Cout(cout_unused), .Ovf(add_ovf)
  );

  // One Booth step. The true sign of the 33-bit sum (Sum[31]^Ovf) is what
  // shifts into HI[31], which keeps the product exact even for M=0x80000000.
  always_comb begin
    step_hi   = hi;
    step_sign = hi[31];
    if (lo[0] ^ q1) begin
      step_hi   = add_sum;
      step_sign = add_sum[31] ^ add_ovf;
    end
    sh_hi = {step_sign, step_hi[31:1]};
    sh_lo = {step_hi[0], lo[31:1]};
    sh_q1 = lo[0];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ctrl_mult && !start_zero) state_nxt = RUN;
      RUN: begin
        if (ctrl_mult)               state_nxt = start_zero ? IDLE : RUN;
        else if (cnt == 6'd31)       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m              <= '0;
      hi             <= '0;
      lo             <= '0;
      q1             <= 1'b0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef MULT_ZERO_BYPASS_EN
      zpend          <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (!HOLD_RESULT && data_resultRDY) begin
        data_result    <= '0;
        data_exception <= 1'b0;
      end
      // A start always wins, including over a step that would complete.
      if (ctrl_mult) begin
        m   <= data_operandA;
        hi  <= '0;
        lo  <= data_operandB;
        q1  <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        hi  <= sh_hi;
        lo  <= sh_lo;
        q1  <= sh_q1;
        cnt <= cnt + 6'd1;
        if (cnt == 6'd31) begin
          data_result    <= sh_lo;
          data_exception <= (sh_hi != {32{sh_lo[31]}});
          data_resultRDY <= 1'b1;
        end
      end
`ifdef MULT_ZERO_BYPASS_EN
      zpend <= ctrl_mult && start_zero;
      if (zpend) begin
        data_result    <= '0;
        data_exception <= 1'b0;
        data_resultRDY <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_csa_booth_mult_ctrl.sv
// Scoreboard bench for csa_booth_mult_ctrl: the driver pushes the expected
// product (from plain 64-bit signed arithmetic) and latency per start; a
// monitor pops on each ready pulse and compares result, exception, latency
// and number of busy cycles.
module tb_csa_booth_mult_ctrl;
  logic        clock, reset, ctrl_mult;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        data_exception, data_resultRDY, busy;

  csa_booth_mult_ctrl dut (
    .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks, errors;
  int   de, last_end;           // driver edge index, abortable completion edge
  int   edge_n, start_edge, bcnt;
  logic s_start, s_rst;
  exp_t em;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    de++;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p;
    // A start inside a running operation (up to and including its final
    // step edge) cancels it; a zero-bypass op cannot be cancelled.
    if (de <= last_end && q.size() > 0) void'(q.pop_back());
    p     = longint'($signed(a)) * longint'($signed(b));
    e.res = p[31:0];
    e.exc = (p != longint'($signed(p[31:0])));
    e.lat = 32;
`ifdef MULT_ZERO_BYPASS_EN
    if (a == 32'd0 || b == 32'd0) e.lat = 1;
`endif
    q.push_back(e);
    last_end      = (e.lat == 32) ? de + 32 : -1;
    data_operandA = a;
    data_operandB = b;
    ctrl_mult     = 1'b1;
    tick();
    ctrl_mult     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    last_end = -1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 16'hFFFF));
      5: return -32'($urandom_range(1, 16'hFFFF));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0; errors = 0; de = 0; last_end = -1;
    edge_n = 0; start_edge = 0; bcnt = 0;
    reset = 1'b1; ctrl_mult = 1'b0;
    data_operandA = '0; data_operandB = '0;

    fork
      forever begin
        @(posedge clock);
        s_start = ctrl_mult && !reset;
        s_rst   = reset;
        #1;
        edge_n++;
        if (s_rst) begin
          chk("reset_outputs", {29'd0, data_result, data_exception, data_resultRDY, busy}, 64'd0);
          bcnt = 0;
        end
        if (data_resultRDY) begin
          if (q.size() == 0) chk("spurious_ready", {63'd0, data_resultRDY}, 64'd0);
          else begin
            em = q.pop_front();
            chk("result", {32'd0, data_result}, {32'd0, em.res});
            chk("exception", {63'd0, data_exception}, {63'd0, em.exc});
            chk("latency", 64'(edge_n - start_edge), 64'(em.lat));
            chk("busy_cycles", 64'(bcnt), (em.lat == 1) ? 64'd0 : 64'd32);
          end
        end
        if (s_start) begin
          start_edge = edge_n;
          bcnt = 0;
        end
        if (busy) bcnt++;
      end
    join_none

    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Directed cases
    issue(32'd3, 32'd4);                   repeat (40) tick();
    issue(32'hFFFF_FFF9, 32'd6);           repeat (40) tick();
    issue(32'h7FFF_FFFF, 32'd2);           repeat (40) tick();
    issue(32'h8000_0000, 32'hFFFF_FFFF);   repeat (40) tick();
    issue(32'h0001_0000, 32'h0001_0000);   repeat (40) tick();
    issue(32'h8000_0000, 32'h8000_0000);   repeat (40) tick();

    // Restart: the first operation must not report
    issue(32'd5, 32'd5);                   repeat (9) tick();
    issue(32'd2, 32'd9);                   repeat (40) tick();

    // Reset in mid-operation: no ready afterwards
    issue(32'd100, 32'd100);               repeat (13) tick();
    do_reset();                            repeat (40) tick();

    // Zero operands (bypass or full path depending on the build)
    issue(32'd0, 32'h1234_5678);           repeat (40) tick();
    issue(32'h1234_5678, 32'd0);           tick();
    issue(32'd7, 32'd0);                   repeat (40) tick();

    // Randomized ops with random gaps (short gaps exercise restarts)
    for (int i = 0; i < 60; i++) begin
      issue(pick(), pick());
      repeat ($urandom_range(0, 40)) tick();
    end

    for (int i = 0; i < 100 && q.size() > 0; i++) tick();
    chk("drain_pending", 64'(q.size()), 64'd0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
